// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared state type and default constants for the SR command front-end
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } sr_state_t;

    localparam int DEB_CYCLES_DEF = 16;
    localparam int PULSE_LEN_DEF  = 1;
    localparam int GAP_LEN_DEF    = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - per-channel synchroniser, debounce filter and rising-edge strobe
module sr_debounce
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int              CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous request line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Filtered level flips only after DEB_CYCLES consecutive disagreeing samples; strobe on 0->1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt >= LAST) begin
                cnt   <= '0;
                level <= ~level;
                rise  <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sr_cmd_ctrl.sv
// rtl/sr_cmd_ctrl.sv - pending-command arbitration, pulse/gap sequencing and registered S/R drive
module sr_cmd_ctrl
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int PULSE_LEN  = PULSE_LEN_DEF,
    parameter int GAP_LEN    = GAP_LEN_DEF,
    parameter bit SUPPRESS   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic dropped
);

    localparam int            CW         = $clog2(max_int(PULSE_LEN, GAP_LEN) + 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    logic          set_rise;
    logic          clr_rise;
    logic          pend_set;
    logic          pend_clr;
    logic          pend_set_nxt;
    logic          pend_clr_nxt;
    sr_state_t     state;
    sr_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          s_nxt;
    logic          r_nxt;
    logic          conflict_nxt;
    logic          dropped_nxt;
    logic          suppressed;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (set_req),
        .rise  (set_rise)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (clr_req),
        .rise  (clr_rise)
    );

    // Clear is served first, so the target level is 0 whenever a clear is pending
    assign suppressed = SUPPRESS && (q_fb == !pend_clr);
    assign busy       = (state != IDLE);

    // Next-state logic: serve pending commands from IDLE, time the pulse and the gap
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        s_nxt        = S;
        r_nxt        = R;
        conflict_nxt = 1'b0;
        dropped_nxt  = 1'b0;
        pend_set_nxt = pend_set;
        pend_clr_nxt = pend_clr;
        case (state)
            IDLE: begin
                if (pend_clr || pend_set) begin
                    pend_set_nxt = 1'b0;
                    pend_clr_nxt = 1'b0;
                    conflict_nxt = pend_clr && pend_set;
                    if (suppressed) begin
                        dropped_nxt = !(pend_clr && pend_set);
                    end else begin
                        state_nxt = PULSE;
                        cnt_nxt   = PULSE_LOAD;
                        s_nxt     = !pend_clr;
                        r_nxt     = pend_clr;
                    end
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    s_nxt = 1'b0;
                    r_nxt = 1'b0;
                    if (GAP_LEN > 0) begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                s_nxt     = 1'b0;
                r_nxt     = 1'b0;
            end
        endcase
        pend_set_nxt = pend_set_nxt | set_rise;
        pend_clr_nxt = pend_clr_nxt | clr_rise;
    end

    // State, pend bits and all registered outputs; reset drops S/R without waiting for clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_set <= 1'b0;
            pend_clr <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pend_set <= pend_set_nxt;
            pend_clr <= pend_clr_nxt;
            S        <= s_nxt;
            R        <= r_nxt;
            conflict <= conflict_nxt;
            dropped  <= dropped_nxt;
        end
    end

endmodule

// File: tb/tb_sr_cmd_ctrl.sv
// tb/tb_sr_cmd_ctrl.sv - randomized self-checking bench for sr_cmd_ctrl against a timestamp reference model
module tb_sr_cmd_ctrl;

    localparam int D    = 4;
    localparam int NM   = 3;
    localparam int HMAX = 8192;

    int p_len [NM] = '{1, 1, 3};
    int g_len [NM] = '{2, 2, 2};
    bit sup   [NM] = '{1'b1, 1'b0, 1'b1};

    logic clk;
    logic rst_n;
    logic set_req;
    logic clr_req;
    logic q_fb;
    logic o_s    [NM];
    logic o_r    [NM];
    logic o_busy [NM];
    logic o_conf [NM];
    logic o_drop [NM];

    int n_checks;
    int n_fail;

    // model state: raw history, filtered levels, strobes, pend bits, pulse timestamps
    bit hs [HMAX];
    bit hc [HMAX];
    int ecnt;
    bit f_s;
    bit f_c;
    bit rise_s;
    bit rise_c;
    bit pend_s    [NM];
    bit pend_c    [NM];
    int pstart    [NM];
    int idle_from [NM];
    bit ptgt      [NM];
    bit conf_e    [NM];
    bit drop_e    [NM];

    sr_cmd_ctrl #(.DEB_CYCLES(D), .PULSE_LEN(1), .GAP_LEN(2), .SUPPRESS(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
        .S(o_s[0]), .R(o_r[0]), .busy(o_busy[0]), .conflict(o_conf[0]), .dropped(o_drop[0])
    );

    sr_cmd_ctrl #(.DEB_CYCLES(D), .PULSE_LEN(1), .GAP_LEN(2), .SUPPRESS(1'b0)) u_dut_ns (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
        .S(o_s[1]), .R(o_r[1]), .busy(o_busy[1]), .conflict(o_conf[1]), .dropped(o_drop[1])
    );

    sr_cmd_ctrl #(.DEB_CYCLES(D), .PULSE_LEN(3), .GAP_LEN(2), .SUPPRESS(1'b1)) u_dut_p3 (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
        .S(o_s[2]), .R(o_r[2]), .busy(o_busy[2]), .conflict(o_conf[2]), .dropped(o_drop[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        f_s    = 1'b0;
        f_c    = 1'b0;
        rise_s = 1'b0;
        rise_c = 1'b0;
        for (int m = 0; m < NM; m++) begin
            pend_s[m]    = 1'b0;
            pend_c[m]    = 1'b0;
            pstart[m]    = -1000;
            idle_from[m] = 0;
            ptgt[m]      = 1'b0;
            conf_e[m]    = 1'b0;
            drop_e[m]    = 1'b0;
        end
    endtask

    // true when the D synchronised samples before this edge all differ from lvl
    function automatic bit window_differs(input bit ch, input bit lvl);
        int idx;
        bit v;
        for (int j = 0; j < D; j++) begin
            idx = ecnt - 2 - j;
            v = (idx >= 0) ? (ch ? hc[idx] : hs[idx]) : 1'b0;
            if (v == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit ns;
        bit nc;
        bit both;
        bit tgt;
        bit supd;
        ecnt++;
        hs[ecnt] = rst_n ? set_req : 1'b0;
        hc[ecnt] = rst_n ? clr_req : 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int m = 0; m < NM; m++) begin
            conf_e[m] = 1'b0;
            drop_e[m] = 1'b0;
            if (ecnt >= idle_from[m] && (pend_s[m] || pend_c[m])) begin
                both = pend_s[m] && pend_c[m];
                tgt  = !pend_c[m];
                supd = sup[m] && (q_fb == tgt);
                conf_e[m] = both;
                drop_e[m] = supd && !both;
                pend_s[m] = 1'b0;
                pend_c[m] = 1'b0;
                if (!supd) begin
                    pstart[m]    = ecnt;
                    ptgt[m]      = tgt;
                    idle_from[m] = ecnt + p_len[m] + g_len[m] + 1;
                end
            end
            pend_s[m] = pend_s[m] | rise_s;
            pend_c[m] = pend_c[m] | rise_c;
        end
        ns = 1'b0;
        nc = 1'b0;
        if (window_differs(1'b0, f_s)) begin
            f_s = ~f_s;
            ns  = f_s;
        end
        if (window_differs(1'b1, f_c)) begin
            f_c = ~f_c;
            nc  = f_c;
        end
        rise_s = ns;
        rise_c = nc;
    endtask

    task automatic compare_all();
        bit in_p;
        bit in_b;
        for (int m = 0; m < NM; m++) begin
            in_p = (ecnt >= pstart[m]) && (ecnt < pstart[m] + p_len[m]);
            in_b = (ecnt >= pstart[m]) && (ecnt < pstart[m] + p_len[m] + g_len[m]);
            chk($sformatf("S%0d", m), o_s[m], in_p && ptgt[m]);
            chk($sformatf("R%0d", m), o_r[m], in_p && !ptgt[m]);
            chk($sformatf("busy%0d", m), o_busy[m], in_b);
            chk($sformatf("conflict%0d", m), o_conf[m], conf_e[m]);
            chk($sformatf("dropped%0d", m), o_drop[m], drop_e[m]);
            chk($sformatf("s_and_r%0d", m), o_s[m] & o_r[m], 0);
            chk($sformatf("conf_and_drop%0d", m), o_conf[m] & o_drop[m], 0);
        end
    endtask

    // one clock: drive at negedge, step model at posedge, compare at next negedge
    task automatic tick(input logic s, input logic c, input logic q, input logic rn);
        logic was_rn;
        was_rn  = rst_n;
        set_req = s;
        clr_req = c;
        q_fb    = q;
        rst_n   = rn;
        if (!rn) model_reset();
        if (!rn && was_rn) begin
            #1;
            for (int m = 0; m < NM; m++) begin
                chk($sformatf("async_S%0d", m), o_s[m], 0);
                chk($sformatf("async_R%0d", m), o_r[m], 0);
            end
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int lat;
        int c_s0;
        int c_s1;
        int c_s2;
        int c_r0;
        int c_b0;
        int c_cf;
        int c_dr;
        int c_dr1;
        int fall_e;
        int rise_e;
        bit seen;
        bit prev_s;
        logic rs;
        logic rc;
        logic rq;
        logic rr;
        int len;

        n_checks = 0;
        n_fail   = 0;
        ecnt     = 0;
        rst_n    = 1'b0;
        set_req  = 1'b0;
        clr_req  = 1'b0;
        q_fb     = 1'b0;
        model_reset();
        @(negedge clk);

        repeat (3) tick(0, 0, 0, 0);
        chk("rst_S", o_s[0], 0);
        chk("rst_busy", o_busy[0], 0);
        repeat (2) tick(0, 0, 0, 1);

        // 1: single set command, latency, widths
        lat = 0;
        while (o_s[0] !== 1'b1 && lat < 40) begin
            tick(1, 0, 0, 1);
            lat++;
        end
        chk("t1_latency", lat, D + 4);
        c_s0 = o_s[0]; c_b0 = o_busy[0]; c_s2 = o_s[2]; c_r0 = o_r[0];
        repeat (10) begin
            tick(1, 0, 0, 1);
            c_s0 += o_s[0]; c_b0 += o_busy[0]; c_s2 += o_s[2]; c_r0 += o_r[0];
        end
        chk("t1_s_width", c_s0, 1);
        chk("t1_busy_width", c_b0, 3);
        chk("t1_p3_width", c_s2, 3);
        chk("t1_no_r", c_r0, 0);
        repeat (10) tick(0, 0, 0, 1);

        // 2: short glitch rejected, D-cycle pulse accepted
        c_s0 = 0;
        repeat (3) begin tick(1, 0, 0, 1); c_s0 += o_s[0]; end
        repeat (12) begin tick(0, 0, 0, 1); c_s0 += o_s[0]; end
        chk("t2_glitch", c_s0, 0);
        c_s0 = 0;
        repeat (4) begin tick(1, 0, 0, 1); c_s0 += o_s[0]; end
        repeat (14) begin tick(0, 0, 0, 1); c_s0 += o_s[0]; end
        chk("t2_pulse", c_s0, 1);

        // 3: simultaneous set and clear
        c_s0 = 0; c_r0 = 0; c_cf = 0;
        repeat (14) begin
            tick(1, 1, 1, 1);
            c_s0 += o_s[0]; c_r0 += o_r[0]; c_cf += o_conf[0];
        end
        chk("t3_r", c_r0, 1);
        chk("t3_s", c_s0, 0);
        chk("t3_conflict", c_cf, 1);
        repeat (10) tick(0, 0, 1, 1);

        // 4: suppression when already set, and SUPPRESS=0 instance pulses anyway
        c_s0 = 0; c_s1 = 0; c_dr = 0; c_dr1 = 0;
        repeat (14) begin
            tick(1, 0, 1, 1);
            c_s0 += o_s[0]; c_s1 += o_s[1]; c_dr += o_drop[0]; c_dr1 += o_drop[1];
        end
        chk("t4_dropped", c_dr, 1);
        chk("t4_no_s", c_s0, 0);
        chk("t4_ns_s", c_s1, 1);
        chk("t4_ns_dropped", c_dr1, 0);
        repeat (10) tick(0, 0, 1, 1);

        // 5: clear arrives just after set pulse starts; gap spacing
        seen = 1'b0; prev_s = 1'b0; fall_e = -1; rise_e = -1;
        for (int i = 0; i < 30; i++) begin
            tick(1, (i >= 1), seen, 1);
            if (o_s[0]) seen = 1'b1;
            if (prev_s && !o_s[0] && fall_e < 0) fall_e = i;
            if (o_r[0] && rise_e < 0) rise_e = i;
            prev_s = o_s[0];
        end
        chk("t5_s_seen", seen, 1);
        chk("t5_gap", rise_e - fall_e, 3);
        repeat (10) tick(0, 0, 0, 1);

        // 6: reset mid-pulse, request held through reset
        lat = 0;
        while (o_s[0] !== 1'b1 && lat < 40) begin
            tick(1, 0, 0, 1);
            lat++;
        end
        chk("t6_pre_s", o_s[0], 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        lat = 0;
        while (o_s[0] !== 1'b1 && lat < 40) begin
            tick(1, 0, 0, 1);
            lat++;
        end
        chk("t6_latency", lat, D + 4);
        repeat (10) tick(0, 0, 0, 1);

        // random phases of holds, glitches, q_fb changes and resets
        rq = 1'b0;
        for (int it = 0; it < 150; it++) begin
            rs  = 1'($urandom_range(0, 1));
            rc  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rq = ~rq;
            rr  = ($urandom_range(0, 29) != 0);
            len = $urandom_range(1, 12);
            repeat (len) tick(rs, rc, rq, rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
